// File: rtl/pipe_hazard.sv
// pipe_hazard: tracks in-flight destinations, selects forwarding, stalls on load-use, squashes wrong-path slots
module pipe_hazard #(
    parameter int REG_IDX_W   = 5,
    parameter int DEPTH       = 3,
    parameter int LOAD_LAT    = 1,
    parameter int FLUSH_SLOTS = 2,
    parameter int SEL_W       = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 id_valid,
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic [REG_IDX_W-1:0] id_rs2,
    input  logic                 id_rs1_used,
    input  logic                 id_rs2_used,
    input  logic [REG_IDX_W-1:0] id_rd,
    input  logic                 id_reg_write,
    input  logic                 id_is_load,
    input  logic                 ex_taken,
    output logic                 stall,
    output logic                 kill,
    output logic [SEL_W-1:0]     fwd_sel1,
    output logic [SEL_W-1:0]     fwd_sel2,
    output logic                 wb_en,
    output logic [REG_IDX_W-1:0] wb_rd
);
    localparam int FC_W = $clog2(FLUSH_SLOTS + 1);

    logic [DEPTH:1]                v, rw, ld;
    logic [DEPTH:1][REG_IDX_W-1:0] rd;
    logic [FC_W-1:0]               fcnt;
    logic                          ex_eff, acc, f1, f2, a1, a2;
    logic [SEL_W-1:0]              p1, p2;
    logic [REG_IDX_W-1:0]          rd_in;

    assign ex_eff = ex_taken & v[1];

    // youngest in-flight producer per operand (x0 never matches) and whether its result is ready
    always_comb begin
        f1 = 1'b0;
        a1 = 1'b0;
        p1 = '0;
        f2 = 1'b0;
        a2 = 1'b0;
        p2 = '0;
        for (int k = DEPTH; k >= 1; k--) begin
            if (v[k] && rw[k] && id_rs1 != '0 && rd[k] == id_rs1) begin
                f1 = 1'b1;
                p1 = SEL_W'(k);
                a1 = !ld[k] || k >= 1 + LOAD_LAT;
            end
            if (v[k] && rw[k] && id_rs2 != '0 && rd[k] == id_rs2) begin
                f2 = 1'b1;
                p2 = SEL_W'(k);
                a2 = !ld[k] || k >= 1 + LOAD_LAT;
            end
        end
    end

    assign stall    = id_valid & (fcnt == '0) & ~ex_eff &
                      ((id_rs1_used & f1 & ~a1) | (id_rs2_used & f2 & ~a2));
    assign acc      = id_valid & ~stall & (fcnt == '0) & ~ex_eff;
    assign rd_in    = acc ? id_rd : '0;
    assign fwd_sel1 = (f1 & a1 & id_rs1_used) ? p1 : '0;
    assign fwd_sel2 = (f2 & a2 & id_rs2_used) ? p2 : '0;
    assign kill     = ~v[1];
    assign wb_en    = v[DEPTH] & rw[DEPTH] & (rd[DEPTH] != '0);
    assign wb_rd    = rd[DEPTH];

    // advance the tracking pipe one stage and run the post-branch squash counter
    always_ff @(posedge clk) begin
        if (rst) begin
            v    <= '0;
            rw   <= '0;
            ld   <= '0;
            rd   <= '0;
            fcnt <= '0;
        end else begin
            v    <= {v[DEPTH-1:1], acc};
            rw   <= {rw[DEPTH-1:1], acc & id_reg_write};
            ld   <= {ld[DEPTH-1:1], acc & id_is_load};
            rd   <= {rd[DEPTH-1:1], rd_in};
            fcnt <= ex_eff ? FC_W'(FLUSH_SLOTS - 1) : fcnt - FC_W'(fcnt != '0);
        end
    end
endmodule

// File: doc/pipe_hazard.md
# pipe_hazard

Parametrised hazard and flush controller for the in-order RISC-V pipeline. It tracks in-flight destination registers from EX to writeback and selects forwarding sources for both decode operands. It stalls decode on load-use hazards, which the current core cannot do. It also squashes a configurable number of wrong-path slots after a taken branch, replacing the fixed delay-line masking in the core top. It sits between decode/control and the EX operand muxes, regfile write-enable and memory-enable gating.

## Interface
- REG_IDX_W, 5, register index width
- DEPTH, 3, tracked stages after decode (stage 1 = EX, stage DEPTH = WB), ≥2
- LOAD_LAT, 1, extra stages before a load result is forwardable (available from stage 1+LOAD_LAT), < DEPTH
- FLUSH_SLOTS, 2, younger decode slots squashed after a taken branch, ≥1
- SEL_W, $clog2(DEPTH+1), forward-select width

- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- id_valid  in  1  decode slot holds an instruction
- id_rs1, id_rs2  in  REG_IDX_W  source indices
- id_rs1_used, id_rs2_used  in  1  operand actually read
- id_rd  in  REG_IDX_W  destination index
- id_reg_write  in  1  instruction writes rd
- id_is_load  in  1  instruction is a load (incl. FPU load to int reg)
- ex_taken  in  1  branch/jump in EX resolved taken
- stall  out  1  hold PC and IF/ID this cycle
- kill  out  1  EX-stage entry is invalid; gate memory write/read enables
- fwd_sel1, fwd_sel2  out  SEL_W  0 = regfile, k = stage k result
- wb_en  out  1  regfile write enable
- wb_rd  out  REG_IDX_W  regfile write index

## Operation
- State: DEPTH entries {valid, rd, reg_write, is_load}, shifted k→k+1 every cycle, plus flush counter fcnt, 0..FLUSH_SLOTS.
- Entering entry 1 each cycle:
  - id fields with valid = id_valid & ~stall & (fcnt==0);
  - otherwise a bubble (valid=0).
- ex_eff = ex_taken & entry1.valid. ex_taken with invalid entry 1 is ignored.
- On ex_eff: fcnt ← FLUSH_SLOTS-1 (the slot decoding this cycle is already squashed by ex_eff); else if fcnt≠0 then fcnt ← fcnt-1.
  - Decode entry valid is also forced 0 when ex_eff=1.
- Match(k, rs) = entry k valid & reg_write & rd==rs & rs≠0. Register x0 never forwards or stalls.
- Producer for rs = smallest k with Match. It is available if ~is_load, or k ≥ 1+LOAD_LAT.
- fwd_selN = producer k if one exists and is available and operand used, else 0.
- Stall is combinational: stall = id_valid & (fcnt==0) & ~ex_eff & ∃ used operand whose producer is not available.
  - On stall, ID holds and entry 1 takes a bubble. The stall repeats until the load reaches stage 1+LOAD_LAT.
- Flush priority: ex_eff or fcnt≠0 forces stall=0.
- kill = ~entry1.valid.
- wb_en = entryDEPTH.valid & reg_write & rd≠0; wb_rd = entryDEPTH.rd.

## Timing
- Reset: all entries invalid, fcnt=0. Outputs: stall=0, kill=1, fwd_sel1/2=0, wb_en=0, wb_rd=0.
- rst dominates ex_taken and all decode input. Reset mid-flush clears fcnt on the same edge.
- stall, fwd_sel and kill are combinational from current state and id/ex inputs, valid in the same cycle. wb_en and wb_rd come from registered state only.
- Instruction accepted at edge t reaches stage k during cycle t+k.
- Load-use with LOAD_LAT=1: exactly 1 stall cycle when the consumer immediately follows the load, 0 when it is one slot later.
- Squash: after ex_eff in cycle t, decode slots of cycles t..t+FLUSH_SLOTS-1 never become valid entries.
- Stage DEPTH forwarding covers the same-cycle regfile write/read case.

## Test plan
- Reset: hold rst 2 cycles with id_valid=1 and ex_taken=1 -> stall=0, kill=1, wb_en=0 and fwd_sel=0 during and 1 cycle after.
- ALU chain (DEPTH=3): add rd=5 accepted; next cycle rs1=5 used -> fwd_sel1=1, stall=0. One slot later -> fwd_sel1=2. Three cycles later -> wb_en=1, wb_rd=5.
- Load-use (LOAD_LAT=1): load rd=7, then rs2=7 used -> stall=1 for exactly 1 cycle and a bubble in stage 1 (kill=1 next cycle). Then fwd_sel2=2, stall=0.
- x0 and unused operands: producer rd=0 with reg_write, consumer rs1=0 -> fwd_sel1=0, no stall, wb_en=0. rs2 matches a pending load but id_rs2_used=0 -> no stall.
- Branch squash (FLUSH_SLOTS=2): ex_taken with valid EX entry, two writing instructions in decode slots t and t+1 -> neither produces wb_en, and stall=0 even if they hazard. Slot t+2 proceeds normally. ex_taken while entry 1 invalid -> no flush.
- Reset mid-flush: rst one cycle after ex_eff -> fcnt=0 after the edge, and the next valid decode is accepted.
